// File: rtl/ace_snapshot_dumper.sv
// Ace snapshot dumper: streams Ace memory BASE_ADDR..end_addr to the host, one byte per
// handshake, substituting latched CPU register bytes inside the register window.
module ace_snapshot_dumper #(
    parameter logic [15:0] BASE_ADDR = 16'h2000,
    parameter logic [7:0]  REG_PAGE  = 8'h21
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [15:0]  end_addr,
    input  logic [211:0] cpu_regs,
    output logic         dump_en,
    output logic [15:0]  mem_addr,
    output logic         mem_rd,
    input  logic [7:0]   mem_data,
    output logic [15:0]  out_addr,
    output logic [7:0]   out_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic         busy,
    output logic         done
);
    localparam int unsigned AW = 16;
    localparam int unsigned DW = 8;
    localparam int unsigned RW = 212;

    typedef enum logic [2:0] {S_IDLE, S_RD, S_CAP, S_SEND, S_FIN} state_t;

    state_t        state, state_d;
    logic [AW-1:0] cur, cur_d, end_q, end_d;
    logic [RW-1:0] regs_q, regs_d;
    logic          dump_en_d, mem_rd_d, out_valid_d, busy_d, done_d;
    logic [AW-1:0] mem_addr_d, out_addr_d;
    logic [DW-1:0] out_data_d;

    function automatic logic in_window(input logic [AW-1:0] a);
        return (a[15:8] == REG_PAGE) && !a[7];
    endfunction

    // Register-window byte layout, matching what the loader consumes.
    function automatic logic [DW-1:0] regbyte(input logic [RW-1:0] r, input logic [6:0] off);
        logic [DW-1:0] b;
        b = 8'h00;
        case (off)
            7'h00: b = r[15:8];
            7'h01: b = r[7:0];
            7'h04: b = r[87:80];
            7'h05: b = r[95:88];
            7'h08: b = r[103:96];
            7'h09: b = r[111:104];
            7'h0C: b = r[119:112];
            7'h0D: b = r[127:120];
            7'h10: b = r[135:128];
            7'h11: b = r[143:136];
            7'h14: b = r[199:192];
            7'h15: b = r[207:200];
            7'h18: b = r[55:48];
            7'h19: b = r[63:56];
            7'h1C: b = r[71:64];
            7'h1D: b = r[79:72];
            7'h20: b = r[31:24];
            7'h21: b = r[23:16];
            7'h24: b = r[151:144];
            7'h25: b = r[159:152];
            7'h28: b = r[167:160];
            7'h29: b = r[175:168];
            7'h2C: b = r[183:176];
            7'h2D: b = r[191:184];
            7'h30: b = {6'b0, r[209:208]};
            7'h34: b = {7'b0, r[210]};
            7'h38: b = {7'b0, r[211]};
            7'h3C: b = r[39:32];
            7'h40: b = r[47:40];
            default: b = 8'h00;
        endcase
        return b;
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            cur       <= BASE_ADDR;
            end_q     <= '0;
            regs_q    <= '0;
            dump_en   <= 1'b0;
            mem_addr  <= BASE_ADDR;
            mem_rd    <= 1'b0;
            out_addr  <= BASE_ADDR;
            out_data  <= '0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= state_d;
            cur       <= cur_d;
            end_q     <= end_d;
            regs_q    <= regs_d;
            dump_en   <= dump_en_d;
            mem_addr  <= mem_addr_d;
            mem_rd    <= mem_rd_d;
            out_addr  <= out_addr_d;
            out_data  <= out_data_d;
            out_valid <= out_valid_d;
            busy      <= busy_d;
            done      <= done_d;
        end
    end

    // Next state and next registered outputs; mem_rd and done are single-cycle strobes.
    always_comb begin
        state_d     = state;
        cur_d       = cur;
        end_d       = end_q;
        regs_d      = regs_q;
        dump_en_d   = dump_en;
        mem_addr_d  = mem_addr;
        mem_rd_d    = 1'b0;
        out_addr_d  = out_addr;
        out_data_d  = out_data;
        out_valid_d = out_valid;
        busy_d      = busy;
        done_d      = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    end_d  = end_addr;
                    regs_d = cpu_regs;
                    cur_d  = BASE_ADDR;
                    if (end_addr < BASE_ADDR) begin
                        state_d = S_FIN;
                        done_d  = 1'b1;
                    end else begin
                        state_d    = S_RD;
                        dump_en_d  = 1'b1;
                        busy_d     = 1'b1;
                        mem_addr_d = BASE_ADDR;
                        mem_rd_d   = !in_window(BASE_ADDR);
                    end
                end
            end
            S_RD: state_d = S_CAP;
            S_CAP: begin
                out_data_d  = in_window(cur) ? regbyte(regs_q, cur[6:0]) : mem_data;
                out_addr_d  = cur;
                out_valid_d = 1'b1;
                state_d     = S_SEND;
            end
            S_SEND: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    if (cur == end_q) begin
                        state_d   = S_FIN;
                        done_d    = 1'b1;
                        dump_en_d = 1'b0;
                        busy_d    = 1'b0;
                    end else begin
                        cur_d      = cur + AW'(1);
                        state_d    = S_RD;
                        mem_addr_d = cur_d;
                        mem_rd_d   = !in_window(cur_d);
                    end
                end
            end
            S_FIN: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end
endmodule

// File: tb/tb_ace_snapshot_dumper.sv
// Bench for ace_snapshot_dumper: random memory and register images, captured host stream
// compared against an address-walk reference model.
module tb_ace_snapshot_dumper;
    logic         clk, reset, start, start_hi, out_ready;
    logic [15:0]  end_addr;
    logic [211:0] cpu_regs;
    logic         dump_en, mem_rd, out_valid, busy, done;
    logic [15:0]  mem_addr, out_addr;
    logic [7:0]   mem_data, out_data;
    logic         h_dump_en, h_mem_rd, h_out_valid, h_busy, h_done;
    logic [15:0]  h_mem_addr, h_out_addr;
    logic [7:0]   h_mem_data, h_out_data;

    int total = 0;
    int bad = 0;

    logic [7:0] mem [0:65535];

    // Main instance at the default base; a second one near the top of memory keeps the
    // end-of-address-space run short.
    ace_snapshot_dumper u_dut (
        .clk(clk), .reset(reset), .start(start), .end_addr(end_addr), .cpu_regs(cpu_regs),
        .dump_en(dump_en), .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_data(mem_data),
        .out_addr(out_addr), .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .busy(busy), .done(done)
    );

    ace_snapshot_dumper #(.BASE_ADDR(16'hFF00), .REG_PAGE(8'h21)) u_hi (
        .clk(clk), .reset(reset), .start(start_hi), .end_addr(end_addr), .cpu_regs(cpu_regs),
        .dump_en(h_dump_en), .mem_addr(h_mem_addr), .mem_rd(h_mem_rd), .mem_data(h_mem_data),
        .out_addr(h_out_addr), .out_data(h_out_data), .out_valid(h_out_valid), .out_ready(out_ready),
        .busy(h_busy), .done(h_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_rd)   mem_data   <= mem[mem_addr];
        if (h_mem_rd) h_mem_data <= mem[h_mem_addr];
    end

    bit          sel_hi = 1'b0;
    logic        m_valid, m_done, m_dump_en, m_busy, m_mem_rd;
    logic [15:0] m_addr, m_mem_addr;
    logic [7:0]  m_data;
    assign m_valid    = sel_hi ? h_out_valid : out_valid;
    assign m_done     = sel_hi ? h_done      : done;
    assign m_dump_en  = sel_hi ? h_dump_en   : dump_en;
    assign m_busy     = sel_hi ? h_busy      : busy;
    assign m_mem_rd   = sel_hi ? h_mem_rd    : mem_rd;
    assign m_mem_addr = sel_hi ? h_mem_addr  : mem_addr;
    assign m_addr     = sel_hi ? h_out_addr  : out_addr;
    assign m_data     = sel_hi ? h_out_data  : out_data;

    // Register image layout as (window offset, first bit, width) triples.
    int unsigned reg_off [29] = '{'h00,'h01,'h04,'h05,'h08,'h09,'h0C,'h0D,'h10,'h11,'h14,'h15,
                                  'h18,'h19,'h1C,'h1D,'h20,'h21,'h24,'h25,'h28,'h29,'h2C,'h2D,
                                  'h30,'h34,'h38,'h3C,'h40};
    int unsigned reg_lsb [29] = '{8,0,80,88,96,104,112,120,128,136,192,200,
                                  48,56,64,72,24,16,144,152,160,168,176,184,
                                  208,210,211,32,40};
    int unsigned reg_w   [29] = '{8,8,8,8,8,8,8,8,8,8,8,8,8,8,8,8,8,8,8,8,8,8,8,8,2,1,1,8,8};

    function automatic logic [7:0] ref_byte(input int unsigned a, input logic [211:0] r);
        logic [211:0] t;
        if (a >= 'h2100 && a <= 'h217F) begin
            for (int k = 0; k < 29; k++)
                if (reg_off[k] == a - 'h2100) begin
                    t = r >> reg_lsb[k];
                    return t[7:0] & 8'((1 << reg_w[k]) - 1);
                end
            return 8'h00;
        end
        return mem[a];
    endfunction

    function automatic logic [211:0] rand_regs();
        logic [211:0] r;
        for (int i = 0; i < 212; i++) r[i] = 1'($urandom);
        return r;
    endfunction

    logic [15:0] cap_addr [$];
    logic [7:0]  cap_data [$];
    int n_done, done_cyc, stall_err, win_rd, valid_seen, en_err;
    bit busy_at1, timed_out, en_after;

    // Mismatches between captured stream and the walk base..ea of the reference image.
    function automatic int count_stream_diffs(input int unsigned base, input int unsigned ea,
                                              input logic [211:0] r);
        int n, errs;
        n = (ea < base) ? 0 : int'(ea - base + 1);
        errs = (cap_addr.size() != n) ? 1 : 0;
        for (int i = 0; i < n && i < cap_addr.size(); i++)
            if (cap_addr[i] !== 16'(base + i) || cap_data[i] !== ref_byte(base + i, r)) errs++;
        return errs;
    endfunction

    // ready_mode: 0 always ready, 1 ready one cycle in four, 2 random.
    task automatic run_dump(input bit hi, input logic [15:0] ea, input logic [211:0] r,
                            input int ready_mode, input int restart_at, input int max_cyc);
        bit hold;
        logic [15:0] h_a;
        logic [7:0]  h_d;
        cap_addr.delete(); cap_data.delete();
        n_done = 0; done_cyc = -1; stall_err = 0; win_rd = 0; valid_seen = 0; en_err = 0;
        busy_at1 = 1'b0; hold = 1'b0; h_a = '0; h_d = '0;
        sel_hi = hi;
        @(negedge clk);
        end_addr = ea; cpu_regs = r;
        if (hi) start_hi = 1'b1; else start = 1'b1;
        for (int cyc = 1; cyc <= max_cyc; cyc++) begin
            @(negedge clk);
            start = 1'b0; start_hi = 1'b0;
            if (cyc == restart_at) begin
                if (hi) start_hi = 1'b1; else start = 1'b1;
                end_addr = 16'($urandom);
                cpu_regs = rand_regs();
            end
            case (ready_mode)
                0: out_ready = 1'b1;
                1: out_ready = (cyc % 4 == 0);
                default: out_ready = 1'($urandom);
            endcase
            if (cyc == 1) busy_at1 = m_busy;
            if (hold && (!m_valid || m_addr !== h_a || m_data !== h_d)) stall_err++;
            if (m_mem_rd && m_mem_addr >= 16'h2100 && m_mem_addr <= 16'h217F) win_rd++;
            if (m_valid) begin
                valid_seen++;
                if (!m_dump_en) en_err++;
            end
            if (m_valid && out_ready) begin
                cap_addr.push_back(m_addr);
                cap_data.push_back(m_data);
                hold = 1'b0;
            end else begin
                hold = m_valid; h_a = m_addr; h_d = m_data;
            end
            if (m_done) begin
                n_done++;
                if (done_cyc < 0) done_cyc = cyc;
            end
            if (done_cyc >= 0 && cyc >= done_cyc + 2) break;
        end
        timed_out = (done_cyc < 0);
        en_after = m_dump_en;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        total++;
        if ({dump_en, mem_rd, out_valid, busy, done} !== 5'b0) begin
            bad++; $display("FAIL reset_ctrl got=%b want=00000", {dump_en, mem_rd, out_valid, busy, done});
        end
        total++;
        if (mem_addr !== 16'h2000) begin bad++; $display("FAIL reset_mem_addr got=%h want=2000", mem_addr); end
        total++;
        if (out_addr !== 16'h2000) begin bad++; $display("FAIL reset_out_addr got=%h want=2000", out_addr); end
        total++;
        if (out_data !== 8'h00) begin bad++; $display("FAIL reset_out_data got=%h want=00", out_data); end
        reset = 1'b0;
    endtask

    task automatic test_basic();
        logic [211:0] r = rand_regs();
        logic [31:0] got;
        mem['h2000] = 8'h11; mem['h2001] = 8'h22; mem['h2002] = 8'h33; mem['h2003] = 8'h44;
        run_dump(1'b0, 16'h2003, r, 0, 0, 200);
        total++;
        if (timed_out) begin bad++; $display("FAIL basic_timeout got=no_done want=done"); end
        total++;
        if (cap_data.size() != 4) begin
            bad++; $display("FAIL basic_count got=%0d want=4", cap_data.size());
        end else begin
            got = {cap_data[0], cap_data[1], cap_data[2], cap_data[3]};
            total++;
            if (got !== 32'h11223344) begin bad++; $display("FAIL basic_bytes got=%h want=11223344", got); end
        end
        total++;
        if (count_stream_diffs('h2000, 'h2003, r) != 0) begin bad++; $display("FAIL basic_stream got=diffs want=0"); end
        total++;
        if (n_done != 1) begin bad++; $display("FAIL basic_done got=%0d want=1", n_done); end
        total++;
        if (done_cyc != 13) begin bad++; $display("FAIL basic_rate got=%0d want=13", done_cyc); end
        total++;
        if (busy_at1 !== 1'b1 || en_after !== 1'b0) begin
            bad++; $display("FAIL basic_busy_en got=%b%b want=10", busy_at1, en_after);
        end
    endtask

    task automatic test_regs();
        logic [211:0] r = rand_regs();
        r[7:0] = 8'h5A; r[79:72] = 8'hC3; r[209:208] = 2'd2; r[210] = 1'b1;
        run_dump(1'b0, 16'h2180, r, 0, 0, 2000);
        total++;
        if (cap_data.size() != 'h181) begin
            bad++; $display("FAIL regs_count got=%0d want=385", cap_data.size());
        end else begin
            total++;
            if (cap_data['h101] !== 8'h5A) begin bad++; $display("FAIL regs_a got=%h want=5a", cap_data['h101]); end
            total++;
            if (cap_data['h11D] !== 8'hC3) begin bad++; $display("FAIL regs_pch got=%h want=c3", cap_data['h11D]); end
            total++;
            if (cap_data['h130] !== 8'h02) begin bad++; $display("FAIL regs_im got=%h want=02", cap_data['h130]); end
            total++;
            if (cap_data['h134] !== 8'h01) begin bad++; $display("FAIL regs_iff1 got=%h want=01", cap_data['h134]); end
            total++;
            if (cap_data['h102] !== 8'h00) begin bad++; $display("FAIL regs_unlisted got=%h want=00", cap_data['h102]); end
            total++;
            if (cap_data['h180] !== mem['h2180]) begin
                bad++; $display("FAIL regs_2180 got=%h want=%h", cap_data['h180], mem['h2180]);
            end
        end
        total++;
        if (count_stream_diffs('h2000, 'h2180, r) != 0) begin bad++; $display("FAIL regs_stream got=diffs want=0"); end
        total++;
        if (win_rd != 0) begin bad++; $display("FAIL regs_window_rd got=%0d want=0", win_rd); end
    endtask

    task automatic test_stall();
        logic [211:0] r = rand_regs();
        logic [15:0] ea = 16'('h20F8 + $urandom_range(0, 24));
        run_dump(1'b0, ea, r, 1, 0, 3000);
        total++;
        if (stall_err != 0) begin bad++; $display("FAIL stall_stable got=%0d want=0", stall_err); end
        total++;
        if (count_stream_diffs('h2000, ea, r) != 0) begin bad++; $display("FAIL stall_stream got=diffs want=0"); end
        total++;
        if (en_err != 0 || timed_out) begin bad++; $display("FAIL stall_en got=%0d/%0d want=0/0", en_err, timed_out); end
    endtask

    task automatic test_start_busy();
        logic [211:0] r = rand_regs();
        logic [15:0] ea = 16'('h2108 + $urandom_range(0, 16));
        run_dump(1'b0, ea, r, 2, 20, 3000);
        total++;
        if (count_stream_diffs('h2000, ea, r) != 0) begin bad++; $display("FAIL busy_start_stream got=diffs want=0"); end
        total++;
        if (n_done != 1) begin bad++; $display("FAIL busy_start_done got=%0d want=1", n_done); end
    endtask

    task automatic test_empty();
        logic [15:0] ea = 16'($urandom_range(0, 'h1FFF));
        run_dump(1'b0, ea, rand_regs(), 0, 0, 20);
        total++;
        if (done_cyc != 1) begin bad++; $display("FAIL empty_done_cyc got=%0d want=1", done_cyc); end
        total++;
        if (valid_seen != 0) begin bad++; $display("FAIL empty_valid got=%0d want=0", valid_seen); end
        total++;
        if (n_done != 1) begin bad++; $display("FAIL empty_done_count got=%0d want=1", n_done); end
    endtask

    task automatic test_top_end();
        logic [211:0] r = rand_regs();
        run_dump(1'b1, 16'hFFFF, r, 0, 0, 2000);
        total++;
        if (cap_addr.size() != 256) begin
            bad++; $display("FAIL top_count got=%0d want=256", cap_addr.size());
        end else begin
            total++;
            if (cap_addr[255] !== 16'hFFFF) begin bad++; $display("FAIL top_last got=%h want=ffff", cap_addr[255]); end
        end
        total++;
        if (count_stream_diffs('hFF00, 'hFFFF, r) != 0) begin bad++; $display("FAIL top_stream got=diffs want=0"); end
        total++;
        if (n_done != 1 || valid_seen != 256) begin
            bad++; $display("FAIL top_end got=done%0d/valid%0d want=done1/valid256", n_done, valid_seen);
        end
        total++;
        if (h_mem_addr !== 16'hFFFF) begin bad++; $display("FAIL top_nowrap got=%h want=ffff", h_mem_addr); end
        sel_hi = 1'b0;
    endtask

    task automatic test_reset_mid();
        logic [211:0] r = rand_regs();
        int waited = 0;
        sel_hi = 1'b0;
        out_ready = 1'b0;
        @(negedge clk);
        end_addr = 16'h2010; cpu_regs = r; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        while (!out_valid && waited < 20) begin @(negedge clk); waited++; end
        total++;
        if (!out_valid) begin bad++; $display("FAIL mid_reach_send got=0 want=1"); end
        reset = 1'b1;
        @(negedge clk);
        total++;
        if ({dump_en, mem_rd, out_valid, busy, done} !== 5'b0 || out_addr !== 16'h2000
            || mem_addr !== 16'h2000 || out_data !== 8'h00) begin
            bad++;
            $display("FAIL mid_reset got=%b/%h/%h/%h want=00000/2000/2000/00",
                     {dump_en, mem_rd, out_valid, busy, done}, out_addr, mem_addr, out_data);
        end
        reset = 1'b0;
        run_dump(1'b0, 16'h2003, r, 0, 0, 200);
        total++;
        if (cap_addr.size() == 0 || cap_addr[0] !== 16'h2000) begin
            bad++; $display("FAIL mid_restart got=%0d bytes want=first at 2000", cap_addr.size());
        end
        total++;
        if (count_stream_diffs('h2000, 'h2003, r) != 0) begin bad++; $display("FAIL mid_stream got=diffs want=0"); end
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; start_hi = 1'b0; out_ready = 1'b0;
        end_addr = '0; cpu_regs = '0;
        for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
        test_reset();
        test_basic();
        test_regs();
        test_stall();
        test_start_busy();
        test_empty();
        test_top_end();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
